// File: rtl/led_frame_sequencer.sv
// LED frame sequencer: holds an 8-column frame buffer written by the host and
// periodically streams one refresh frame (data cmd, address cmd, 8 column bytes,
// display-control byte) to the LED byte writer over a valid/busy handshake.
module led_frame_sequencer #(
    parameter int         NUM_COLS       = 8,
    parameter int         REFRESH_CYCLES = 12_000,
    parameter logic [7:0] CMD_DATA       = 8'h40,
    parameter logic [7:0] CMD_ADDR       = 8'hC0,
    parameter logic [7:0] CMD_DISP_BASE  = 8'h88
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic [2:0] brightness,
    output logic [7:0] px_value,
    output logic       px_valid,
    input  logic       px_busy,
    output logic       frame_active,
    output logic       frame_done,
    output logic       overrun
);

    localparam int         CNT_W    = $clog2(REFRESH_CYCLES);
    localparam logic [3:0] LAST_IDX = 4'd10;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        WAIT_ACK,
        WAIT_DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] refresh_cnt;
    logic             tick;
    logic [7:0]       fb   [NUM_COLS];
    logic [7:0]       snap [NUM_COLS];
    logic [2:0]       bri_lat;
    logic [3:0]       byte_idx;
    logic [7:0]       cur_byte;

    assign tick = (refresh_cnt == CNT_W'(REFRESH_CYCLES - 1));

    // Byte to send for the current index; columns come from the frozen snapshot
    function automatic logic [7:0] frame_byte(input logic [3:0] idx,
                                              input logic [7:0] col,
                                              input logic [2:0] bri);
        logic [7:0] b;
        case (idx)
            4'd0:    b = CMD_DATA;
            4'd1:    b = CMD_ADDR;
            4'd10:   b = CMD_DISP_BASE | {5'b00000, bri};
            default: b = col;
        endcase
        return b;
    endfunction

    // Select the column byte for the current index and format the outgoing byte
    always_comb begin
        cur_byte = frame_byte(byte_idx, snap[3'(byte_idx - 4'd2)], bri_lat);
    end

    // Free-running refresh timer; tick marks the wrap and is never gated
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            refresh_cnt <= '0;
        end else if (tick) begin
            refresh_cnt <= '0;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

    // Host-side frame buffer, writable in every state
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_COLS; i++) begin
                fb[i] <= '0;
            end
        end else if (wr_en) begin
            fb[wr_addr] <= wr_data;
        end
    end

    // Frame sequencing FSM with registered handshake and status outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            byte_idx     <= '0;
            bri_lat      <= '0;
            px_value     <= '0;
            px_valid     <= 1'b0;
            frame_active <= 1'b0;
            frame_done   <= 1'b0;
            overrun      <= 1'b0;
            for (int i = 0; i < NUM_COLS; i++) begin
                snap[i] <= '0;
            end
        end else begin
            frame_done <= 1'b0;
            // A tick during a frame is dropped, only flagged
            if (tick && (state != IDLE)) begin
                overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (tick) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    for (int i = 0; i < NUM_COLS; i++) begin
                        snap[i] <= fb[i];
                    end
                    // Write-through so a same-cycle host write lands in this frame
                    if (wr_en) begin
                        snap[wr_addr] <= wr_data;
                    end
                    bri_lat      <= brightness;
                    byte_idx     <= '0;
                    frame_active <= 1'b1;
                    state        <= SEND;
                end
                SEND: begin
                    if (!px_busy) begin
                        px_value <= cur_byte;
                        px_valid <= 1'b1;
                        state    <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (px_busy) begin
                        px_valid <= 1'b0;
                        state    <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (!px_busy) begin
                        if (byte_idx == LAST_IDX) begin
                            frame_done   <= 1'b1;
                            frame_active <= 1'b0;
                            state        <= IDLE;
                        end else begin
                            byte_idx <= byte_idx + 4'd1;
                            state    <= SEND;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/led_frame_sequencer.md
Name: led_frame_sequencer

Overview:
Upstream feeder for the LED-array byte writer (writepixel). Holds an 8-column x 8-bit frame buffer written by the host logic, and refreshes the display periodically. Each refresh sends an 11-byte command/data sequence to the writer over a valid/busy handshake: data command, address command, 8 column bytes, display-control byte.

Parameters:
NUM_COLS, 8, columns per frame (fixed 8; wr_addr width 3)
REFRESH_CYCLES, 12_000, clk cycles between frame starts (1 ms at 12 MHz)
CMD_DATA, 8'h40, data command byte (auto-increment address)
CMD_ADDR, 8'hC0, start-address command byte
CMD_DISP_BASE, 8'h88, display-on base; brightness ORed into bits [2:0]

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
wr_en  in  1  frame-buffer write strobe
wr_addr  in  3  column index for write
wr_data  in  8  column bit pattern
brightness  in  3  display brightness; sampled at frame start
px_value  out  8  byte to writer
px_valid  out  1  byte-request to writer
px_busy  in  1  writer busy (clock-domain-safe level; may rise several cycles after valid)
frame_active  out  1  high from frame start until last byte completes
frame_done  out  1  one-cycle pulse when last byte completes
overrun  out  1  sticky; set when refresh tick arrives while frame_active; cleared only by reset

Behaviour:
- Reset (async, resetn low): all outputs 0, state IDLE, frame buffer and snapshot cleared, refresh counter 0, byte index 0.
- Frame buffer: wr_en writes wr_data to fb[wr_addr] at posedge clk; writes are accepted in every state.
- Refresh counter: free-running 0..REFRESH_CYCLES-1. The tick occurs at wrap and is gated by nothing; the first tick comes REFRESH_CYCLES cycles after reset release.
- States:
  - IDLE: on tick -> LOAD.
  - LOAD (1 cycle): copy fb to snapshot; latch brightness; byte index=0; frame_active<=1; -> SEND. A write in the same cycle as LOAD is included in the snapshot (write-through).
  - SEND: if px_busy==0, drive px_value=byte[index], px_valid<=1 -> WAIT_ACK. If px_busy==1, stay.
  - WAIT_ACK: hold px_valid=1 and px_value stable until px_busy sampled 1; then px_valid<=0 -> WAIT_DONE.
  - WAIT_DONE: on px_busy==0: if index==10 -> IDLE, pulse frame_done, frame_active<=0; else index+1 -> SEND.
- Byte order: index 0=CMD_DATA, 1=CMD_ADDR, 2..9=snapshot col0..col7, 10=CMD_DISP_BASE|brightness_latched.
- Tick while frame_active: set overrun; the tick is not queued. The next frame starts at the next tick after IDLE.
- Host writes during a frame affect only the next frame.
- px_valid never asserts outside SEND/WAIT_ACK. At most one byte is outstanding.
- Index is 4 bits wide and never exceeds 10.

Test Plan:
- Reset, write fb[0..7]=8'h01,02,04,..,80, brightness=3; writer model with 20-cycle busy, rising 3 cycles after valid -> bytes 40,C0,01,02,04,08,10,20,40,80,8B in order; one frame_done pulse; px_valid drops the cycle after busy seen high.
- Write fb[3]=8'hFF during an in-progress frame -> current frame still sends the old col3; the next frame sends FF.
- Write fb[5]=8'hAA in the exact LOAD cycle -> the same frame sends AA at index 7.
- REFRESH_CYCLES=100, writer busy 15 cycles/byte (frame >100 cycles) -> overrun=1 and stays 1; frames start only at ticks while IDLE; no byte lost or duplicated.
- Assert resetn low mid-byte (in WAIT_ACK) -> px_valid, frame_active, overrun=0 immediately; after release, the first frame sends a zero snapshot (cols all 00).
- px_busy held high at frame start for 50 cycles -> px_valid stays 0 until busy falls, then asserts with px_value=8'h40.
